// File: rtl/bool_lut_eval.sv
// Clocked, reprogrammable N-input boolean function held as a truth table.
// Includes a self-test sweep that reads back every table entry and counts minterms.
module bool_lut_eval #(
  parameter int N_IN = 3,
  localparam int TT_W = 2 ** N_IN,
  parameter logic [TT_W-1:0] DEF_TT = 8'h57
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  input  logic [N_IN-1:0] i_in_vec,
  output logic            o_out_valid,
  output logic            o_y,
  input  logic            i_cfg_we,
  input  logic [TT_W-1:0] i_cfg_tt,
  output logic            o_cfg_err,
  input  logic            i_sweep_start,
  output logic            o_sweep_busy,
  output logic            o_sweep_done,
  output logic [N_IN:0]   o_sweep_count,
  output logic [TT_W-1:0] o_sweep_tt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [TT_W-1:0]   r_tt;
  logic              r_y;
  logic              r_out_valid;
  logic              r_cfg_err;
  logic [N_IN-1:0]   r_idx;
  logic [N_IN:0]     r_cnt;
  logic [TT_W-1:0]   r_shadow;
  logic [N_IN:0]     r_sweep_count;
  logic [TT_W-1:0]   r_sweep_tt;
  logic              r_busy;
  logic              r_done;

  logic              w_bit;
  logic [N_IN:0]     w_cnt_next;
  logic [TT_W-1:0]   w_shadow_next;
  logic              w_cfg_blocked;

  assign w_bit         = r_tt[r_idx];
  assign w_cnt_next    = r_cnt + {{N_IN{1'b0}}, w_bit};
  assign w_cfg_blocked = (r_state == S_RUN);

  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = w_bit;
  end

  // Evaluation reads the table before any same-edge write, so a racing
  // configuration only affects inputs sampled from the following edge on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tt        <= DEF_TT;
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_y <= r_tt[i_in_vec];
      end
      r_cfg_err <= i_cfg_we && w_cfg_blocked;
      if (i_cfg_we && !w_cfg_blocked) begin
        r_tt <= i_cfg_tt;
      end
    end
  end

  // busy/done are registered from the state, so they trail it by one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_sweep_count <= '0;
      r_sweep_tt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy <= (r_state == S_RUN);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          r_idx    <= '0;
          r_cnt    <= '0;
          r_shadow <= '0;
          if (i_sweep_start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt    <= w_cnt_next;
          r_shadow <= w_shadow_next;
          if (&r_idx) begin
            r_idx         <= '0;
            r_state       <= S_DONE;
            r_sweep_count <= w_cnt_next;
            r_sweep_tt    <= w_shadow_next;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_y           = r_y;
  assign o_out_valid   = r_out_valid;
  assign o_cfg_err     = r_cfg_err;
  assign o_sweep_busy  = r_busy;
  assign o_sweep_done  = r_done;
  assign o_sweep_count = r_sweep_count;
  assign o_sweep_tt    = r_sweep_tt;

endmodule

// File: tb/tb_bool_lut_eval.sv
// Directed self-checking bench for bool_lut_eval with the default 3-input
// function y = a'b' + c' (a = in_vec[2], c = in_vec[0]).
module tb_bool_lut_eval;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_in_valid;
  logic [2:0] i_in_vec;
  logic       o_out_valid;
  logic       o_y;
  logic       i_cfg_we;
  logic [7:0] i_cfg_tt;
  logic       o_cfg_err;
  logic       i_sweep_start;
  logic       o_sweep_busy;
  logic       o_sweep_done;
  logic [3:0] o_sweep_count;
  logic [7:0] o_sweep_tt;

  int nTests = 0;
  int nFail  = 0;

  bool_lut_eval #(.N_IN(3), .DEF_TT(8'h57)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_in_valid    (i_in_valid),
    .i_in_vec      (i_in_vec),
    .o_out_valid   (o_out_valid),
    .o_y           (o_y),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_tt      (i_cfg_tt),
    .o_cfg_err     (o_cfg_err),
    .i_sweep_start (i_sweep_start),
    .o_sweep_busy  (o_sweep_busy),
    .o_sweep_done  (o_sweep_done),
    .o_sweep_count (o_sweep_count),
    .o_sweep_tt    (o_sweep_tt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Pulses sweep_start and waits a bounded number of cycles for sweep_done.
  task automatic do_sweep(output bit timedOut);
    i_sweep_start = 1'b1;
    tick();
    i_sweep_start = 1'b0;
    timedOut = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_sweep_done) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    nTests++;
    if (o_y !== 1'b0 || o_out_valid !== 1'b0) begin
      $display("[TB] FAIL reset_eval: got y=%b ov=%b expected 0 0", o_y, o_out_valid); nFail++;
    end
    nTests++;
    if (o_sweep_busy !== 1'b0 || o_sweep_done !== 1'b0 || o_sweep_count !== 4'd0 ||
        o_sweep_tt !== 8'h00 || o_cfg_err !== 1'b0) begin
      $display("[TB] FAIL reset_sweep: got busy=%b done=%b cnt=%0d tt=%h err=%b expected all 0",
               o_sweep_busy, o_sweep_done, o_sweep_count, o_sweep_tt, o_cfg_err); nFail++;
    end
    #19;
    i_rst_n = 1'b1;
    tick();
    i_in_valid = 1'b1;
    i_in_vec   = 3'd0;
    tick();
    i_in_valid = 1'b0;
    nTests++;
    if (o_y !== 1'b1 || o_out_valid !== 1'b1) begin
      $display("[TB] FAIL post_reset_eval0: got y=%b ov=%b expected 1 1", o_y, o_out_valid); nFail++;
    end
    // Mid-cycle asynchronous reset must clear outputs without a clock edge.
    #3;
    i_rst_n = 1'b0;
    #1;
    nTests++;
    if (o_y !== 1'b0 || o_out_valid !== 1'b0) begin
      $display("[TB] FAIL async_reset: got y=%b ov=%b expected 0 0", o_y, o_out_valid); nFail++;
    end
    #2;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_default_function();
    logic a, b, c, expY;
    for (int i = 0; i < 8; i++) begin
      i_in_valid = 1'b1;
      i_in_vec   = 3'(i);
      tick();
      a = i_in_vec[2]; b = i_in_vec[1]; c = i_in_vec[0];
      expY = (!a && !b) || !c;
      nTests++;
      if (o_y !== expY || o_out_valid !== 1'b1) begin
        $display("[TB] FAIL default_fn_vec%0d: got y=%b ov=%b expected %b 1", i, o_y, o_out_valid, expY); nFail++;
      end
    end
    i_in_valid = 1'b0;
    tick();
    nTests++;
    if (o_out_valid !== 1'b0 || o_y !== 1'b0) begin
      $display("[TB] FAIL default_fn_hold: got y=%b ov=%b expected 0 0", o_y, o_out_valid); nFail++;
    end
  endtask

  task automatic test_sweep_default();
    i_sweep_start = 1'b1;
    tick();
    i_sweep_start = 1'b0;
    nTests++;
    if (o_sweep_busy !== 1'b0) begin
      $display("[TB] FAIL sweep_busy_edge0: got %b expected 0", o_sweep_busy); nFail++;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      nTests++;
      if (o_sweep_busy !== 1'b1 || o_sweep_done !== 1'b0) begin
        $display("[TB] FAIL sweep_busy_edge%0d: got busy=%b done=%b expected 1 0", k, o_sweep_busy, o_sweep_done); nFail++;
      end
    end
    tick();
    nTests++;
    if (o_sweep_busy !== 1'b0 || o_sweep_done !== 1'b1) begin
      $display("[TB] FAIL sweep_done_edge9: got busy=%b done=%b expected 0 1", o_sweep_busy, o_sweep_done); nFail++;
    end
    nTests++;
    if (o_sweep_count !== 4'd5 || o_sweep_tt !== 8'h57) begin
      $display("[TB] FAIL sweep_default_result: got cnt=%0d tt=%h expected 5 57", o_sweep_count, o_sweep_tt); nFail++;
    end
    tick();
    nTests++;
    if (o_sweep_done !== 1'b0 || o_sweep_count !== 4'd5) begin
      $display("[TB] FAIL sweep_done_pulse: got done=%b cnt=%0d expected 0 5", o_sweep_done, o_sweep_count); nFail++;
    end
  endtask

  task automatic test_reconfig_race();
    bit timedOut;
    i_cfg_we   = 1'b1;
    i_cfg_tt   = 8'h80;
    i_in_valid = 1'b1;
    i_in_vec   = 3'd7;
    tick();
    i_cfg_we = 1'b0;
    nTests++;
    if (o_y !== 1'b0) begin
      $display("[TB] FAIL race_old_table: got y=%b expected 0", o_y); nFail++;
    end
    tick();
    i_in_valid = 1'b0;
    nTests++;
    if (o_y !== 1'b1) begin
      $display("[TB] FAIL race_new_table: got y=%b expected 1", o_y); nFail++;
    end
    do_sweep(timedOut);
    nTests++;
    if (timedOut || o_sweep_count !== 4'd1 || o_sweep_tt !== 8'h80) begin
      $display("[TB] FAIL race_sweep: got timeout=%b cnt=%0d tt=%h expected 0 1 80", timedOut, o_sweep_count, o_sweep_tt); nFail++;
    end
    tick();
  endtask

  task automatic test_cfg_during_sweep();
    bit timedOut;
    i_cfg_we = 1'b1;
    i_cfg_tt = 8'h57;
    tick();
    i_cfg_we = 1'b0;
    i_sweep_start = 1'b1;
    tick();
    i_sweep_start = 1'b0;
    tick(); tick(); tick();
    i_cfg_we = 1'b1;
    i_cfg_tt = 8'hFF;
    tick();
    i_cfg_we = 1'b0;
    nTests++;
    if (o_cfg_err !== 1'b1) begin
      $display("[TB] FAIL cfg_err_pulse: got %b expected 1", o_cfg_err); nFail++;
    end
    tick();
    nTests++;
    if (o_cfg_err !== 1'b0) begin
      $display("[TB] FAIL cfg_err_clear: got %b expected 0", o_cfg_err); nFail++;
    end
    timedOut = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (o_sweep_done) begin
        timedOut = 1'b0;
        break;
      end
      tick();
    end
    nTests++;
    if (timedOut || o_sweep_count !== 4'd5 || o_sweep_tt !== 8'h57) begin
      $display("[TB] FAIL cfg_sweep_result: got timeout=%b cnt=%0d tt=%h expected 0 5 57", timedOut, o_sweep_count, o_sweep_tt); nFail++;
    end
    i_in_valid = 1'b1;
    i_in_vec   = 3'd3;
    tick();
    i_in_valid = 1'b0;
    nTests++;
    if (o_y !== 1'b0) begin
      $display("[TB] FAIL cfg_table_unchanged: got y=%b expected 0", o_y); nFail++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit sawDone;
    i_cfg_we = 1'b1;
    i_cfg_tt = 8'h80;
    tick();
    i_cfg_we = 1'b0;
    i_sweep_start = 1'b1;
    tick();
    i_sweep_start = 1'b0;
    tick(); tick(); tick(); tick();
    nTests++;
    if (o_sweep_busy !== 1'b1) begin
      $display("[TB] FAIL midsweep_busy: got %b expected 1", o_sweep_busy); nFail++;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    nTests++;
    if (o_sweep_busy !== 1'b0 || o_sweep_count !== 4'd0 || o_sweep_tt !== 8'h00) begin
      $display("[TB] FAIL midsweep_reset: got busy=%b cnt=%0d tt=%h expected 0 0 00", o_sweep_busy, o_sweep_count, o_sweep_tt); nFail++;
    end
    #2;
    i_rst_n = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_sweep_done || o_sweep_busy) sawDone = 1'b1;
    end
    nTests++;
    if (sawDone !== 1'b0 || o_sweep_count !== 4'd0) begin
      $display("[TB] FAIL midsweep_no_done: got activity=%b cnt=%0d expected 0 0", sawDone, o_sweep_count); nFail++;
    end
    i_in_valid = 1'b1;
    i_in_vec   = 3'd7;
    tick();
    nTests++;
    if (o_y !== 1'b0) begin
      $display("[TB] FAIL midsweep_def_vec7: got y=%b expected 0", o_y); nFail++;
    end
    i_in_vec = 3'd0;
    tick();
    i_in_valid = 1'b0;
    nTests++;
    if (o_y !== 1'b1) begin
      $display("[TB] FAIL midsweep_def_vec0: got y=%b expected 1", o_y); nFail++;
    end
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_in_valid    = 1'b0;
    i_in_vec      = 3'd0;
    i_cfg_we      = 1'b0;
    i_cfg_tt      = 8'h00;
    i_sweep_start = 1'b0;
    test_reset();
    test_default_function();
    test_sweep_default();
    test_reconfig_race();
    test_cfg_during_sweep();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
